uart_tx: RTL and testbench
==========================

// Module: uart_tx
// PURPOSE
//   Multi-byte UART transmitter; the send-side counterpart of uart_rx.
//   Loads a p_data_buffer-byte word on a one-cycle start strobe and serialises it as
//   back-to-back 8N1 frames on o_tx, most-significant byte first.
//   Bits within each byte go LSB first, so a uart_rx with the same parameters returns the identical word.
// PARAMETERS
//   p_preescaler   8   clk cycles per UART bit (>=2)
//   p_data_buffer  16  bytes per transfer (>=1)
// PORTS
//   clk          in   1                  system clock
//   rst          in   1                  synchronous reset, active-high
//   ip_data      in   8*p_data_buffer    word to send; bits [8*p_data_buffer-1 -: 8] go first
//   i_start      in   1                  one-cycle strobe; accepted only while or_busy==0
//   o_tx         out  1                  UART line, idle high
//   or_busy      out  1                  high from the cycle after acceptance until or_done
//   or_done      out  1                  one-cycle pulse when the last stop bit has completed
// BEHAVIOUR
//   Clock and reset: one clock, clk; rst is synchronous, active-high.
//   Reset values: o_tx=1, or_busy=0, or_done=0, FSM=ST_IDLE, all counters=0.
//   Reset mid-transfer: o_tx returns high on the next edge; the word is discarded; no or_done.
//   Bit timer:
//     - counts 0..p_preescaler-1 and is cleared on acceptance, so bit boundaries align to i_start.
//     - bit_end = (timer == p_preescaler-1).
//     - each line level is held exactly p_preescaler cycles.
//   ST_IDLE:
//     - o_tx=1, or_busy=0.
//     - i_start=1 latches ip_data into a shift buffer and clears the byte and bit counters -> ST_START.
//   ST_START:
//     - o_tx=0; on bit_end -> ST_DATA.
//   ST_DATA:
//     - o_tx = current_byte[bit_idx], bit_idx 0..7.
//     - On bit_end, bit_idx increments; on bit_end with bit_idx==7 -> ST_STOP.
//   ST_STOP:
//     - o_tx=1; on bit_end:
//       - more bytes left: advance to the next byte (byte_idx++, or shift buffer left by 8) -> ST_START.
//       - else -> ST_DONE.
//     - No idle gap between frames of one transfer.
//   ST_DONE:
//     - or_done=1 for exactly one cycle; or_busy drops in the same cycle; o_tx=1.
//     - Next state: ST_IDLE.
//   Cycle-level timing:
//     - Latency: o_tx falls on the first edge after the i_start cycle.
//     - Transfer length: 10*p_preescaler*p_data_buffer cycles of line activity.
//     - or_done asserts on the cycle after the final stop bit ends.
//   Boundary conditions:
//     - i_start while or_busy=1 or in ST_DONE: ignored, no queuing.
//     - ip_data changes after acceptance: no effect on the current transfer.
//     - i_start in the first ST_IDLE cycle after ST_DONE: accepted (back-to-back transfers allowed).
//   Width rules:
//     - byte counter wide enough for p_data_buffer-1 ($clog2, min 1).
//     - timer width $clog2(p_preescaler), min 1.
// TESTING  (p_preescaler=8, p_data_buffer=2 unless stated)
//   1 Reset: hold rst 3 cycles -> o_tx=1, or_busy=0, or_done=0; i_start during rst is ignored.
//   2 Single word: i_start with ip_data=16'hA53C.
//     - o_tx=0 for cycles 1-8.
//     - then 1,0,1,0,0,1,0,1 (0xA5 LSB first), 8 cycles each.
//     - stop bit high, then frame for 0x3C.
//     - or_done exactly at cycle 161; or_busy high for cycles 1-160.
//   3 Busy rejection: second i_start=16'hFFFF at cycle 50 -> waveform identical to test 2, one or_done only.
//   4 Mid-frame reset: rst at cycle 40 -> o_tx=1 from cycle 41, or_done never asserts.
//     - A fresh i_start afterwards transmits correctly.
//   5 Loopback: o_tx into uart_rx, same params, 20 random words, back-to-back starts.
//     - each uart_rx orp_data equals the sent word; or_dv once per word.
//   6 Edge params: p_data_buffer=1, p_preescaler=2, data 8'h00 and 8'hFF.
//     - 20-cycle frame, correct levels, or_done at cycle 21.

Source files
------------

// File: rtl/uart_tx.sv
// Multi-byte 8N1 UART transmitter, MSB byte first, LSB bit first.
// Line and status outputs are registered from the next-state decode.
module uart_tx #(
    parameter int p_preescaler  = 8,
    parameter int p_data_buffer = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [8*p_data_buffer-1:0] ip_data,
    input  logic                       i_start,
    output logic                       o_tx,
    output logic                       or_busy,
    output logic                       or_done
);

    localparam int TW = (p_preescaler > 1) ? $clog2(p_preescaler) : 1;
    localparam int BW = (p_data_buffer > 1) ? $clog2(p_data_buffer) : 1;
    localparam int DW = 8 * p_data_buffer;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [2:0]      bit_q, bit_d;
    logic [BW-1:0]   byte_q, byte_d;
    logic [DW-1:0]   buf_q, buf_d;
    logic            tx_q, tx_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            bit_end;
    logic [7:0]      cur_byte;

    assign bit_end = (timer_q == TW'(p_preescaler - 1));

    always_comb begin
        state_d  = state_q;
        timer_d  = '0;
        bit_d    = bit_q;
        byte_d   = byte_q;
        buf_d    = buf_q;
        tx_d     = 1'b1;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        cur_byte = '0;

        if (state_q == ST_START || state_q == ST_DATA || state_q == ST_STOP) begin
            timer_d = bit_end ? '0 : timer_q + 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    buf_d   = ip_data;
                    byte_d  = '0;
                    bit_d   = '0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (bit_end) begin
                    bit_d = bit_q + 1'b1;
                    if (bit_q == 3'd7) state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (byte_q == BW'(p_data_buffer - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        byte_d  = byte_q + 1'b1;
                        buf_d   = buf_q << 8;
                        bit_d   = '0;
                        state_d = ST_START;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs follow the state being entered so they are glitch-free flops.
        cur_byte = buf_d[DW-1 -: 8];
        unique case (state_d)
            ST_START: begin
                tx_d   = 1'b0;
                busy_d = 1'b1;
            end
            ST_DATA: begin
                tx_d   = cur_byte[bit_d];
                busy_d = 1'b1;
            end
            ST_STOP: begin
                busy_d = 1'b1;
            end
            ST_DONE: begin
                done_d = 1'b1;
            end
            default: begin
                tx_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            buf_q   <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            buf_q   <= buf_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign o_tx    = tx_q;
    assign or_busy = busy_q;
    assign or_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: per-cycle line model plus a behavioural receiver.
// Cycle 1 is the first cycle after the i_start cycle.
module tb_uart_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] ip_data;
    logic        i_start;
    logic        o_tx, or_busy, or_done;
    logic [7:0]  ip_data_e;
    logic        i_start_e;
    logic        o_tx_e, or_busy_e, or_done_e;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx #(.p_preescaler(8), .p_data_buffer(2)) dut (
        .clk(clk), .rst(rst), .ip_data(ip_data), .i_start(i_start),
        .o_tx(o_tx), .or_busy(or_busy), .or_done(or_done)
    );

    uart_tx #(.p_preescaler(2), .p_data_buffer(1)) dut_e (
        .clk(clk), .rst(rst), .ip_data(ip_data_e), .i_start(i_start_e),
        .o_tx(o_tx_e), .or_busy(or_busy_e), .or_done(or_done_e)
    );

    // Expected line level in cycle c for word w, p clocks/bit, n bytes.
    function automatic logic exp_line(input logic [15:0] w, input int p,
                                      input int n, input int c);
        int t, k, b;
        logic [15:0] sh;
        logic [7:0] by;
        t = c - 1;
        if (t < 0 || t >= 10 * p * n) return 1'b1;
        k  = t / (10 * p);
        b  = (t % (10 * p)) / p;
        sh = w >> (8 * (n - 1 - k));
        by = sh[7:0];
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return by[b-1];
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        i_start = 1'b1;
        i_start_e = 1'b1;
        ip_data = 16'h1234;
        ip_data_e = 8'h55;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (o_tx !== 1'b1 || or_busy !== 1'b0 || or_done !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold cyc%0d got tx=%b busy=%b done=%b want 1 0 0",
                         i, o_tx, or_busy, or_done);
            end
            checks++;
            if (o_tx_e !== 1'b1 || or_busy_e !== 1'b0 || or_done_e !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold_e got tx=%b busy=%b done=%b want 1 0 0",
                         o_tx_e, or_busy_e, or_done_e);
            end
        end
        rst = 1'b0;
        i_start = 1'b0;
        i_start_e = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (o_tx !== 1'b1 || or_busy !== 1'b0 || or_done !== 1'b0) begin
                errors++;
                $display("FAIL reset_after got tx=%b busy=%b done=%b want 1 0 0",
                         o_tx, or_busy, or_done);
            end
        end
    endtask

    // Send w; optionally poke a second start at poke_c or reset at rst_c.
    task automatic send_word(input string name, input logic [15:0] w,
                             input int poke_c, input int rst_c);
        logic et, eb, ed;
        int dones;
        dones = 0;
        @(negedge clk);
        ip_data = w;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        ip_data = 16'($urandom);
        for (int c = 1; c <= 175; c++) begin
            if (c > 1) @(negedge clk);
            if (rst_c > 0 && c > rst_c) begin
                et = 1'b1; eb = 1'b0; ed = 1'b0;
            end else begin
                et = exp_line(w, 8, 2, c);
                eb = (c <= 160);
                ed = (c == 161);
            end
            if (or_done === 1'b1) dones++;
            checks++;
            if (o_tx !== et || or_busy !== eb || or_done !== ed) begin
                errors++;
                $display("FAIL %s cyc%0d got tx=%b busy=%b done=%b want %b %b %b",
                         name, c, o_tx, or_busy, or_done, et, eb, ed);
            end
            if (c == poke_c) begin
                i_start = 1'b1;
                ip_data = 16'hFFFF;
            end
            if (c == poke_c + 1) i_start = 1'b0;
            if (c == rst_c) rst = 1'b1;
            if (c == rst_c + 1) rst = 1'b0;
        end
        checks++;
        if (dones !== ((rst_c > 0) ? 0 : 1)) begin
            errors++;
            $display("FAIL %s_done_count got %0d want %0d",
                     name, dones, (rst_c > 0) ? 0 : 1);
        end
    endtask

    task automatic test_single();
        send_word("single", 16'hA53C, -10, -10);
    endtask

    task automatic test_busy_reject();
        send_word("busy_reject", 16'hA53C, 50, -10);
    endtask

    task automatic test_mid_reset();
        send_word("mid_reset", 16'hC3E1, -10, 40);
        send_word("after_reset", 16'h5A0F, -10, -10);
    endtask

    task automatic test_back_to_back();
        logic [15:0] words [20];
        logic line [1:160];
        logic [15:0] got;
        int base;
        for (int i = 0; i < 20; i++) words[i] = 16'($urandom);
        @(negedge clk);
        ip_data = words[0];
        i_start = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            i_start = 1'b0;
            ip_data = 16'($urandom);
            for (int c = 1; c <= 160; c++) begin
                if (c > 1) @(negedge clk);
                line[c] = o_tx;
            end
            got = '0;
            for (int k = 0; k < 2; k++) begin
                base = 1 + k * 80 + 4;
                checks++;
                if (line[base] !== 1'b0 || line[base + 72] !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_framing word%0d byte%0d start=%b stop=%b want 0 1",
                             i, k, line[base], line[base + 72]);
                end
                for (int b = 0; b < 8; b++)
                    got[8 * (1 - k) + b] = line[base + 8 * (b + 1)];
            end
            checks++;
            if (got !== words[i]) begin
                errors++;
                $display("FAIL b2b_word%0d got %h want %h", i, got, words[i]);
            end
            @(negedge clk);
            checks++;
            if (or_done !== 1'b1 || or_busy !== 1'b0) begin
                errors++;
                $display("FAIL b2b_done word%0d got done=%b busy=%b want 1 0",
                         i, or_done, or_busy);
            end
            if (i < 19) begin
                i_start = 1'b1;
                ip_data = 16'($urandom);
            end
            @(negedge clk);
            checks++;
            if (or_done !== 1'b0 || or_busy !== 1'b0 || o_tx !== 1'b1) begin
                errors++;
                $display("FAIL b2b_idle word%0d got done=%b busy=%b tx=%b want 0 0 1",
                         i, or_done, or_busy, o_tx);
            end
            if (i < 19) ip_data = words[i + 1];
        end
        i_start = 1'b0;
    endtask

    task automatic test_edge_params();
        logic [7:0] vals [2];
        logic et, eb, ed;
        vals[0] = 8'h00;
        vals[1] = 8'hFF;
        for (int v = 0; v < 2; v++) begin
            @(negedge clk);
            ip_data_e = vals[v];
            i_start_e = 1'b1;
            @(negedge clk);
            i_start_e = 1'b0;
            ip_data_e = 8'($urandom);
            for (int c = 1; c <= 24; c++) begin
                if (c > 1) @(negedge clk);
                et = exp_line({8'h00, vals[v]}, 2, 1, c);
                eb = (c <= 20);
                ed = (c == 21);
                checks++;
                if (o_tx_e !== et || or_busy_e !== eb || or_done_e !== ed) begin
                    errors++;
                    $display("FAIL edge_%h cyc%0d got tx=%b busy=%b done=%b want %b %b %b",
                             vals[v], c, o_tx_e, or_busy_e, or_done_e, et, eb, ed);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        i_start = 1'b0;
        i_start_e = 1'b0;
        ip_data = '0;
        ip_data_e = '0;
        test_reset();
        test_single();
        test_busy_reject();
        test_mid_reset();
        test_back_to_back();
        test_edge_params();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
